// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass and a per-register busy scoreboard.
// r0 reads as zero and is never busy; busy_cnt tracks the population of the busy vector.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     iss_we,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0]  wr_hit;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_val;

  always_comb begin
    wr_hit = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (we[k]) wr_hit[waddr[k*ADDR_W +: ADDR_W]] = 1'b1;
    end
  end

  // Ascending port order lets the highest-index writer win on address conflicts.
  always_comb begin
    regs_d = regs_q;
    for (int k = 0; k < NUM_WR; k++) begin
      if (we[k] && (waddr[k*ADDR_W +: ADDR_W] != '0))
        regs_d[waddr[k*ADDR_W +: ADDR_W]] = wdata[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = '0;
    for (int r = 1; r < DEPTH; r++) begin
      if (flush)
        busy_d[r] = 1'b0;
      else if (iss_we && (iss_addr == ADDR_W'(r)))
        busy_d[r] = 1'b1;
      else if (wr_hit[r])
        busy_d[r] = 1'b0;
    end
    busy_d[0] = 1'b0;
    for (int r = 0; r < DEPTH; r++) begin
      cnt_d = cnt_d + (ADDR_W+1)'(busy_d[r]);
    end
  end

  always_comb begin
    rdata   = '0;
    rbusy   = '0;
    rd_addr = '0;
    rd_val  = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      rd_addr = raddr[j*ADDR_W +: ADDR_W];
      rd_val  = regs_q[rd_addr];
      for (int k = 0; k < NUM_WR; k++) begin
        if (we[k] && (waddr[k*ADDR_W +: ADDR_W] == rd_addr))
          rd_val = wdata[k*DATA_W +: DATA_W];
      end
      if (rst && re[j] && (rd_addr != '0))
        rdata[j*DATA_W +: DATA_W] = rd_val;
      rbusy[j] = rst & re[j] & (rd_addr != '0) & busy_q[rd_addr] & ~wr_hit[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed and randomized checks of regfile_mp against an array-based reference model.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int DEPTH = 1 << AW;

  logic             clk = 1'b0;
  logic             rst;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic [NR-1:0]    re;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;
  logic             iss_we;
  logic [AW-1:0]    iss_addr;
  logic             flush;
  logic [AW:0]      busy_cnt;

  logic [DW-1:0] m_reg  [DEPTH];
  bit            m_busy [DEPTH];
  int checks = 0;
  int errors = 0;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .iss_we(iss_we), .iss_addr(iss_addr), .flush(flush), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit any_write_to(input logic [AW-1:0] a);
    for (int k = 0; k < NW; k++)
      if (we[k] && waddr[k*AW +: AW] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] exp_rdata(input int j);
    logic [AW-1:0] a;
    a = raddr[j*AW +: AW];
    if (a == 0 || !re[j]) return '0;
    for (int k = NW-1; k >= 0; k--)
      if (we[k] && waddr[k*AW +: AW] == a) return wdata[k*DW +: DW];
    return m_reg[a];
  endfunction

  function automatic bit exp_rbusy(input int j);
    logic [AW-1:0] a;
    a = raddr[j*AW +: AW];
    return re[j] && a != 0 && m_busy[a] && !any_write_to(a);
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int r = 0; r < DEPTH; r++) n += int'(m_busy[r]);
    return n;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < DEPTH; r++) begin
      m_reg[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit nb [DEPTH];
    for (int r = 0; r < DEPTH; r++) begin
      if (r == 0 || flush)                          nb[r] = 1'b0;
      else if (iss_we && iss_addr == AW'(r))        nb[r] = 1'b1;
      else if (any_write_to(AW'(r)))                nb[r] = 1'b0;
      else                                          nb[r] = m_busy[r];
    end
    for (int k = 0; k < NW; k++)
      if (we[k] && waddr[k*AW +: AW] != 0) m_reg[waddr[k*AW +: AW]] = wdata[k*DW +: DW];
    for (int r = 0; r < DEPTH; r++) m_busy[r] = nb[r];
  endtask

  task automatic check_reads();
    for (int j = 0; j < NR; j++) begin
      chk($sformatf("rdata%0d", j), 64'(rdata[j*DW +: DW]), 64'(exp_rdata(j)));
      chk($sformatf("rbusy%0d", j), 64'(rbusy[j]), 64'(exp_rbusy(j)));
    end
  endtask

  task automatic cycle();
    #1 check_reads();
    @(posedge clk);
    model_edge();
    #1 chk("busy_cnt", 64'(busy_cnt), 64'(model_count()));
  endtask

  task automatic idle();
    we = '0; waddr = '0; wdata = '0; iss_we = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  task automatic set_wr(input int k, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[k] = en;
    waddr[k*AW +: AW] = a;
    wdata[k*DW +: DW] = d;
  endtask

  task automatic set_rd(input int j, input logic en, input logic [AW-1:0] a);
    re[j] = en;
    raddr[j*AW +: AW] = a;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    re = '1; raddr = '0;
    set_rd(0, 1'b1, 5'd5);
    model_reset();
    #1 chk("rst_cnt", 64'(busy_cnt), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // 1: everything reads zero and idle after reset
    for (int a = 1; a < DEPTH; a++) begin
      set_rd(0, 1'b1, AW'(a));
      set_rd(1, 1'b1, AW'(a));
      #1 chk("t1_rdata", 64'(rdata), 64'd0);
      chk("t1_rbusy", 64'(rbusy), 64'd0);
    end
    chk("t1_cnt", 64'(busy_cnt), 64'd0);

    // 2: bypass then stored value
    set_wr(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    set_rd(0, 1'b1, 5'd5);
    #1 chk("t2_bypass", 64'(rdata[0 +: DW]), 64'hDEAD_BEEF);
    cycle();
    idle();
    #1 chk("t2_stored", 64'(rdata[0 +: DW]), 64'hDEAD_BEEF);
    cycle();

    // 3: port conflict and r0 write
    set_wr(0, 1'b1, 5'd7, 32'h1111);
    set_wr(1, 1'b1, 5'd7, 32'h2222);
    set_rd(0, 1'b1, 5'd7);
    #1 chk("t3_bypass", 64'(rdata[0 +: DW]), 64'h2222);
    cycle();
    idle();
    #1 chk("t3_stored", 64'(rdata[0 +: DW]), 64'h2222);
    cycle();
    set_wr(0, 1'b1, 5'd0, 32'hFFFF);
    set_rd(0, 1'b1, 5'd0);
    cycle();
    idle();
    #1 chk("t3_r0", 64'(rdata[0 +: DW]), 64'd0);
    cycle();

    // 4: issue then writeback
    iss_we = 1'b1; iss_addr = 5'd9;
    cycle();
    chk("t4_cnt1", 64'(busy_cnt), 64'd1);
    idle();
    set_rd(0, 1'b1, 5'd9);
    #1 chk("t4_busy", 64'(rbusy[0]), 64'd1);
    cycle();
    set_wr(0, 1'b1, 5'd9, 32'h42);
    #1 chk("t4_wb_busy", 64'(rbusy[0]), 64'd0);
    chk("t4_wb_data", 64'(rdata[0 +: DW]), 64'h42);
    cycle();
    chk("t4_cnt0", 64'(busy_cnt), 64'd0);
    idle();

    // 5: issue beats writeback, then flush
    iss_we = 1'b1; iss_addr = 5'd3;
    set_wr(1, 1'b1, 5'd3, 32'h33);
    cycle();
    chk("t5_cnt", 64'(busy_cnt), 64'd1);
    idle();
    set_rd(0, 1'b1, 5'd3);
    #1 chk("t5_data", 64'(rdata[0 +: DW]), 64'h33);
    chk("t5_busy", 64'(rbusy[0]), 64'd1);
    cycle();
    iss_we = 1'b1; iss_addr = 5'd4;
    cycle();
    iss_addr = 5'd6;
    cycle();
    chk("t5_cnt3", 64'(busy_cnt), 64'd3);
    idle();
    flush = 1'b1;
    cycle();
    chk("t5_flush", 64'(busy_cnt), 64'd0);
    idle();

    // 6: asynchronous reset during a write
    iss_we = 1'b1; iss_addr = 5'd10;
    cycle();
    idle();
    set_wr(0, 1'b1, 5'd12, 32'hABCD);
    set_rd(0, 1'b1, 5'd5);
    #2 rst = 1'b0;
    #1 chk("t6_cnt", 64'(busy_cnt), 64'd0);
    chk("t6_rdata", 64'(rdata), 64'd0);
    chk("t6_rbusy", 64'(rbusy), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    idle();
    rst = 1'b1;
    set_rd(0, 1'b1, 5'd12);
    set_rd(1, 1'b1, 5'd5);
    #1 chk("t6_r12", 64'(rdata[0 +: DW]), 64'd0);
    chk("t6_r5", 64'(rdata[DW +: DW]), 64'd0);
    cycle();

    // randomized traffic on a narrow address window to force hits and conflicts
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NW; k++)
        set_wr(k, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7)),
               $urandom);
      for (int j = 0; j < NR; j++)
        set_rd(j, 1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 7)));
      iss_we   = 1'($urandom_range(0, 1));
      iss_addr = AW'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 24) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
